// File: rtl/vape_exec_ctrl.sv
// -----------------------------------------------------------------------------
// vape_exec_ctrl
//
// Configuration and sequencing controller for the VAPE attestation monitor.
// Holds the ER/OR window registers, which are programmed through a small
// memory-mapped window. It tracks one ER execution from arm to completion,
// drives exec_flag, and on a violation sequences a fixed-length reset request.
//
// Config window (word offsets from CFG_BASE):
//   +0 ER_min, +2 ER_max, +4 OR_min, +6 OR_max, +8 CTRL
//   CTRL bit0 = arm, CTRL bit1 = clear cfg_err
//
// Ports:
//   clk        in   system clock, rising edge
//   puc        in   synchronous active-high reset
//   pc         in   current program counter
//   data_en    in   data bus access strobe
//   data_wr    in   data bus write qualifier
//   data_addr  in   data bus address
//   data_wdata in   data bus write data
//   viol       in   combined monitor violation
//   irq        in   interrupt request (only used with the optional abort)
//   ER_min/ER_max/OR_min/OR_max  out  region registers
//   exec_flag  out  1 while the ER completed cleanly (state DONE)
//   state      out  0 IDLE, 1 ARMED, 2 RUN, 3 DONE, 4 VIOL
//   cfg_err    out  sticky: arm rejected because of illegal bounds
//   rst_req    out  reset request, RST_PULSE_LEN cycles after a violation
//
// Optional feature macro: VAPE_EXEC_CTRL_IRQ_ABORT_EN
//   When defined, irq while in RUN aborts to VIOL (priority just below viol).
// -----------------------------------------------------------------------------
module vape_exec_ctrl #(
  parameter logic [15:0] CFG_BASE      = 16'hFF10,
  parameter int unsigned RST_PULSE_LEN = 4
) (
  input  logic        clk,
  input  logic        puc,
  input  logic [15:0] pc,
  input  logic        data_en,
  input  logic        data_wr,
  input  logic [15:0] data_addr,
  input  logic [15:0] data_wdata,
  input  logic        viol,
  input  logic        irq,
  output logic [15:0] ER_min,
  output logic [15:0] ER_max,
  output logic [15:0] OR_min,
  output logic [15:0] OR_max,
  output logic        exec_flag,
  output logic [2:0]  state,
  output logic        cfg_err,
  output logic        rst_req
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_VIOL  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] er_min_q, er_min_d;
  logic [15:0] er_max_q, er_max_d;
  logic [15:0] or_min_q, or_min_d;
  logic [15:0] or_max_q, or_max_d;
  logic        exec_flag_q, exec_flag_d;
  logic        cfg_err_q, cfg_err_d;
  logic        rst_req_q, rst_req_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] last_pc_q;

  logic [15:0] cfg_off;
  logic        cfg_wr;
  logic        reg_wr;
  logic        ctrl_wr;
  logic        bounds_ok;
  logic        in_er;
  logic        cfg_moved;

  // Offset is only meaningful when data_addr >= CFG_BASE; that guard also
  // keeps addresses below the base from wrapping into the window.
  assign cfg_off   = data_addr - CFG_BASE;
  assign cfg_wr    = data_en && data_wr && (data_addr >= CFG_BASE) &&
                     (cfg_off <= 16'd8) && !data_addr[0];
  assign reg_wr    = cfg_wr && (cfg_off != 16'd8);
  assign ctrl_wr   = cfg_wr && (cfg_off == 16'd8);
  assign bounds_ok = (er_min_q <= er_max_q) && (or_min_q <= or_max_q);
  assign in_er     = (pc >= er_min_q) && (pc <= er_max_q);

`ifndef VAPE_EXEC_CTRL_IRQ_ABORT_EN
  logic unused_irq;
  assign unused_irq = irq;
`endif

  always_comb begin
    state_d   = state_q;
    er_min_d  = er_min_q;
    er_max_d  = er_max_q;
    or_min_d  = or_min_q;
    or_max_d  = or_max_q;
    cfg_err_d = cfg_err_q;
    cnt_d     = cnt_q;
    cfg_moved = 1'b0;

    if (viol && (state_q inside {ST_ARMED, ST_RUN, ST_DONE})) begin
      // A violation beats every config write and pc event this cycle.
      state_d = ST_VIOL;
    end
`ifdef VAPE_EXEC_CTRL_IRQ_ABORT_EN
    else if (irq && (state_q == ST_RUN)) begin
      state_d = ST_VIOL;
    end
`endif
    else begin
      if (state_q inside {ST_IDLE, ST_ARMED, ST_DONE}) begin
        if (reg_wr) begin
          case (cfg_off[2:1])
            2'd0:    er_min_d = data_wdata;
            2'd1:    er_max_d = data_wdata;
            2'd2:    or_min_d = data_wdata;
            default: or_max_d = data_wdata;
          endcase
          // Any region change invalidates a pending or completed run.
          state_d   = ST_IDLE;
          cfg_moved = 1'b1;
        end
        if (ctrl_wr) begin
          if (data_wdata[1]) begin
            cfg_err_d = 1'b0;
          end
          if (data_wdata[0]) begin
            cfg_moved = 1'b1;
            if (bounds_ok) begin
              state_d   = ST_ARMED;
              cfg_err_d = 1'b0;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
      end else if (state_q == ST_RUN && ctrl_wr && data_wdata[1]) begin
        // Regions are locked in RUN, but the error flag may still be cleared.
        cfg_err_d = 1'b0;
      end

      // A config write that moved the FSM takes precedence over pc events.
      if (!cfg_moved) begin
        case (state_q)
          ST_ARMED: begin
            if (pc == er_min_q) begin
              state_d = ST_RUN;
            end
          end
          ST_RUN: begin
            if (!in_er) begin
              // Leaving the window is only legal right after the last instr.
              state_d = (last_pc_q == er_max_q) ? ST_DONE : ST_VIOL;
            end
          end
          default: ;
        endcase
      end
    end

    if ((state_d == ST_VIOL) && (state_q != ST_VIOL)) begin
      cnt_d = 4'(RST_PULSE_LEN);
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    rst_req_d   = (cnt_d != 4'd0);
    exec_flag_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (puc) begin
      state_q     <= ST_IDLE;
      er_min_q    <= 16'h0000;
      er_max_q    <= 16'h0000;
      or_min_q    <= 16'h0000;
      or_max_q    <= 16'h0000;
      exec_flag_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      rst_req_q   <= 1'b0;
      cnt_q       <= 4'd0;
      last_pc_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      er_min_q    <= er_min_d;
      er_max_q    <= er_max_d;
      or_min_q    <= or_min_d;
      or_max_q    <= or_max_d;
      exec_flag_q <= exec_flag_d;
      cfg_err_q   <= cfg_err_d;
      rst_req_q   <= rst_req_d;
      cnt_q       <= cnt_d;
      last_pc_q   <= pc;
    end
  end

  assign ER_min    = er_min_q;
  assign ER_max    = er_max_q;
  assign OR_min    = or_min_q;
  assign OR_max    = or_max_q;
  assign exec_flag = exec_flag_q;
  assign state     = state_q;
  assign cfg_err   = cfg_err_q;
  assign rst_req   = rst_req_q;

endmodule

// File: doc/vape_exec_ctrl.md
Name: vape_exec_ctrl

Overview:
- Configuration and sequencing controller for the VAPE attestation monitor.
- Owns the ER/OR window registers, programmed by memory-mapped writes, and locks them while the executable region (ER) runs.
- Tracks one ER execution from arm to completion and drives the EXEC flag.
- On any monitor violation, drops EXEC and sequences a fixed-length reset request to the core.

Parameters:
- CFG_BASE, 16'hFF10, base of the config window. Word offsets: +0 ER_min, +2 ER_max, +4 OR_min, +6 OR_max, +8 CTRL.
- RST_PULSE_LEN, 4, number of cycles rst_req is held high after a violation (legal range 1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge
- puc  in  1  reset, synchronous, active-high
- pc  in  16  current program counter
- data_en  in  1  CPU data bus access strobe
- data_wr  in  1  CPU data bus write qualifier
- data_addr  in  16  CPU data bus address
- data_wdata  in  16  CPU write data
- viol  in  1  combined monitor violation (inverse of the monitor's exec AND)
- irq  in  1  interrupt request to the core (used only with the optional feature)
- ER_min  out  16  executable-region start
- ER_max  out  16  executable-region last instruction address
- OR_min  out  16  output-region start
- OR_max  out  16  output-region end
- exec_flag  out  1  1 = ER completed with no violation since arm
- state  out  3  FSM state: 0 IDLE, 1 ARMED, 2 RUN, 3 DONE, 4 VIOL
- cfg_err  out  1  sticky: arm was rejected because of illegal bounds
- rst_req  out  1  reset request to the core

Behaviour:
- Reset (puc=1 at clk edge): all four region registers = 16'h0000, state = IDLE, exec_flag = 0, cfg_err = 0, rst_req = 0, pulse counter = 0. puc overrides every other event.
- Config write: cfg_wr = data_en & data_wr & data_addr in [CFG_BASE, CFG_BASE+8], word-aligned (addr[0]=0).
  - Region register updates on the next edge, with one cycle latency.
  - Writes are ignored in RUN and VIOL (regions locked).
  - A region write in ARMED or DONE returns the FSM to IDLE and clears exec_flag.
- CTRL write with data_wdata[0]=1 arms the controller. The bounds check uses the register values as they are before this edge.
  - Check passes (ER_min<=ER_max and OR_min<=OR_max): IDLE->ARMED, cfg_err cleared.
  - Check fails: stay IDLE, cfg_err=1.
  - Arm while in ARMED or DONE re-arms: ->ARMED, exec_flag=0.
- CTRL write with data_wdata[1]=1: cfg_err cleared. This is allowed in any state except VIOL.
- State transitions, highest priority first:
  - puc -> IDLE.
  - viol=1 in ARMED, RUN or DONE -> VIOL. This beats arm, config writes and pc events in the same cycle.
  - ARMED: pc==ER_min -> RUN.
  - RUN: last_pc==ER_max and pc outside [ER_min,ER_max] -> DONE. last_pc is the registered pc of the previous cycle.
  - RUN: pc outside [ER_min,ER_max] with last_pc!=ER_max -> VIOL (illegal exit).
  - DONE: stays until the next config write, re-arm or viol.
  - IDLE: viol is ignored.
  - VIOL: absorbing until puc.
- exec_flag: registered, and 1 exactly while state==DONE. It rises on the edge that enters DONE and falls on the edge that leaves DONE.
- rst_req:
  - On entry to VIOL, the counter loads RST_PULSE_LEN and rst_req goes to 1 on the same edge.
  - The counter decrements each cycle, and rst_req drops when the counter reaches 0. This gives exactly RST_PULSE_LEN high cycles.
  - If puc arrives mid-pulse, both rst_req and the counter clear immediately.
- Degenerate windows:
  - ER_min==ER_max is legal. RUN is entered and left on the next out-of-window pc.
  - There is no wrap-around: comparisons are unsigned 16-bit, and the windows never span 16'hFFFF->16'h0000.

Optional Feature:
- Macro: VAPE_EXEC_CTRL_IRQ_ABORT_EN.
- Defined: irq=1 while state==RUN forces RUN->VIOL on the next edge, with priority just below viol. This enforces atomicity inside the controller.
- Undefined: irq is unused, and RUN ignores interrupts; atomicity is left to the monitor's viol input.

Test Plan:
- puc=1 for 1 cycle -> next cycle state=0, all regions 0, exec_flag=0, rst_req=0, cfg_err=0.
- Write ER=0xE000..0xE0FE, OR=0x0400..0x041F, CTRL=1 -> ARMED. Then pc 0xE000 ... 0xE0FE then 0xC000 -> state RUN then DONE, exec_flag=1 from the 0xC000 cycle onward.
- Write ER_min=0xE100, ER_max=0xE000, CTRL=1 -> state stays IDLE, cfg_err=1. Then CTRL=2 -> cfg_err=0.
- In RUN (pc=0xE010), assert viol=1 one cycle -> state=VIOL, exec_flag=0, rst_req high exactly 4 cycles. A write to ER_min is ignored and ER_min stays 0xE000.
- In DONE, write OR_max=0x0500 -> state IDLE, exec_flag=0 next edge. In RUN, pc jumps 0xE010->0xC000 -> VIOL.
- With VAPE_EXEC_CTRL_IRQ_ABORT_EN defined, irq=1 in RUN -> VIOL next edge. Undefined: same stimulus stays RUN.
